// File: rtl/handshake_constant_burst.sv
// handshake_constant_burst: emits REPEAT constant or ramp tokens per accepted ctrl token
module handshake_constant_burst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter longint unsigned VALUE = 0,
  parameter int unsigned REPEAT = 1,
  parameter int unsigned MODE = 0,
  parameter longint unsigned STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  localparam int unsigned RW = $clog2(REPEAT + 1);
  localparam logic [DATA_WIDTH-1:0] VAL = DATA_WIDTH'(VALUE);
  localparam logic [DATA_WIDTH-1:0] STP = DATA_WIDTH'(STEP);
  localparam logic [RW-1:0] REP = RW'(REPEAT);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nx;
  logic [RW-1:0] remaining, remaining_nx;
  logic [DATA_WIDTH-1:0] outs_nx;
  logic last, ctrl_fire, outs_fire;
  assign outs_valid = state == EMIT;
  assign last = state == EMIT && remaining == RW'(1);
  assign ctrl_ready = !rst && (state == IDLE || (last && outs_ready));
  assign ctrl_fire = ctrl_valid && ctrl_ready;
  assign outs_fire = outs_valid && outs_ready;
  // A ctrl handshake (from IDLE or on the last beat) always starts a fresh burst; otherwise a beat advances it
  always_comb begin
    state_nx = state;
    remaining_nx = remaining;
    outs_nx = outs;
    if (ctrl_fire) begin
      state_nx = EMIT;
      remaining_nx = REP;
      outs_nx = VAL;
    end else if (outs_fire) begin
      state_nx = last ? IDLE : EMIT;
      remaining_nx = remaining - RW'(1);
      outs_nx = (last || MODE == 0) ? VAL : outs + STP;
    end
  end
  // State, beat counter and output value registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      outs <= VAL;
    end else begin
      state <= state_nx;
      remaining <= remaining_nx;
      outs <= outs_nx;
    end
  end
endmodule

// File: tb/tb_handshake_constant_burst.sv
// tb_handshake_constant_burst: directed checks of burst length, ramp, back-to-back, stalls and reset
module tb_handshake_constant_burst;
  logic clk = 0, rst = 1;
  logic cv_a = 0, cr_a, ov_a, or_a = 1;
  logic [11:0] o_a;
  logic cv_b = 0, cr_b, ov_b, or_b = 1;
  logic [7:0] o_b;
  logic cv_c = 0, cr_c, ov_c, or_c = 1;
  logic [7:0] o_c;
  logic cv_d = 0, cr_d, ov_d, or_d = 1;
  logic [7:0] o_d;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  handshake_constant_burst #(.DATA_WIDTH(12), .VALUE(64'hE8C), .REPEAT(1), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .ctrl_valid(cv_a), .ctrl_ready(cr_a),
    .outs(o_a), .outs_valid(ov_a), .outs_ready(or_a));
  handshake_constant_burst #(.DATA_WIDTH(8), .VALUE(64'hFE), .REPEAT(4), .MODE(1), .STEP(1)) u_b (
    .clk(clk), .rst(rst), .ctrl_valid(cv_b), .ctrl_ready(cr_b),
    .outs(o_b), .outs_valid(ov_b), .outs_ready(or_b));
  handshake_constant_burst #(.DATA_WIDTH(8), .VALUE(64'h10), .REPEAT(3), .MODE(1), .STEP(3)) u_c (
    .clk(clk), .rst(rst), .ctrl_valid(cv_c), .ctrl_ready(cr_c),
    .outs(o_c), .outs_valid(ov_c), .outs_ready(or_c));
  handshake_constant_burst #(.DATA_WIDTH(8), .VALUE(64'h40), .REPEAT(2), .MODE(1), .STEP(5)) u_d (
    .clk(clk), .rst(rst), .ctrl_valid(cv_d), .ctrl_ready(cr_d),
    .outs(o_d), .outs_valid(ov_d), .outs_ready(or_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({ov_a, ov_b, ov_c, ov_d} !== 4'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0000", {ov_a, ov_b, ov_c, ov_d});
    end
    checks++;
    if (o_a !== 12'hE8C || o_b !== 8'hFE) begin
      errors++;
      $display("FAIL reset_outs: got %h/%h expected e8c/fe", o_a, o_b);
    end
    checks++;
    if ({cr_a, cr_b, cr_c, cr_d} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_ready: got %b expected 0000", {cr_a, cr_b, cr_c, cr_d});
    end
    rst = 0;
    #1;
    checks++;
    if ({cr_a, cr_b, cr_c, cr_d} !== 4'b1111) begin
      errors++;
      $display("FAIL idle_ctrl_ready: got %b expected 1111", {cr_a, cr_b, cr_c, cr_d});
    end
  endtask

  task automatic test_single();
    int hs = 0;
    cv_a = 1;
    tick();
    cv_a = 0;
    checks++;
    if (ov_a !== 1'b1 || o_a !== 12'hE8C) begin
      errors++;
      $display("FAIL single_first: valid=%b outs=%h expected 1/e8c", ov_a, o_a);
    end
    for (int i = 0; i < 5; i++) begin
      if (ov_a && or_a) hs++;
      checks++;
      if (o_a !== 12'hE8C) begin
        errors++;
        $display("FAIL single_const: outs=%h expected e8c", o_a);
      end
      tick();
    end
    checks++;
    if (hs !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d handshakes expected 1", hs);
    end
    checks++;
    if (ov_a !== 1'b0 || cr_a !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: valid=%b ready=%b expected 0/1", ov_a, cr_a);
    end
  endtask

  task automatic test_ramp_wrap();
    logic [7:0] exp_q [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cv_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cv_b = 0;
      checks++;
      if (ov_b !== 1'b1 || o_b !== exp_q[i]) begin
        errors++;
        $display("FAIL ramp_beat%0d: valid=%b outs=%h expected 1/%h", i, ov_b, o_b, exp_q[i]);
      end
    end
    tick();
    checks++;
    if (ov_b !== 1'b0 || o_b !== 8'hFE) begin
      errors++;
      $display("FAIL ramp_end: valid=%b outs=%h expected 0/fe", ov_b, o_b);
    end
  endtask

  task automatic test_back_to_back();
    int ctrl_hs = 1;
    logic [7:0] e;
    cv_c = 1;
    for (int b = 0; b < 6; b++) begin
      tick();
      e = 8'h10 + 8'(3 * (b % 3));
      if (b == 5) cv_c = 0;
      #1;
      if (cv_c && cr_c) ctrl_hs++;
      checks++;
      if (ov_c !== 1'b1 || o_c !== e) begin
        errors++;
        $display("FAIL b2b_beat%0d: valid=%b outs=%h expected 1/%h", b, ov_c, o_c, e);
      end
      checks++;
      if (cr_c !== (b % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b expected %b", b, cr_c, b % 3 == 2);
      end
    end
    checks++;
    if (ctrl_hs !== 2) begin
      errors++;
      $display("FAIL b2b_ctrl_count: got %0d expected 2", ctrl_hs);
    end
    tick();
    checks++;
    if (ov_c !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b expected 0", ov_c);
    end
  endtask

  task automatic test_stall();
    int ctrl_hs = 0, tok = 0;
    logic stalled = 0;
    logic [7:0] prev = '0, e;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (stalled) begin
        checks++;
        if (ov_d !== 1'b1 || o_d !== prev) begin
          errors++;
          $display("FAIL stall_hold: valid=%b outs=%h expected 1/%h", ov_d, o_d, prev);
        end
      end
      or_d = 1'($urandom_range(0, 1));
      cv_d = ctrl_hs < 3;
      #1;
      if (cv_d && cr_d) ctrl_hs++;
      if (ov_d && or_d) begin
        e = (tok % 2 == 0) ? 8'h40 : 8'h45;
        checks++;
        if (o_d !== e) begin
          errors++;
          $display("FAIL stall_order%0d: outs=%h expected %h", tok, o_d, e);
        end
        tok++;
      end
      stalled = ov_d && !or_d;
      prev = o_d;
    end
    cv_d = 0;
    or_d = 1;
    checks++;
    if (tok !== 6 || ctrl_hs !== 3) begin
      errors++;
      $display("FAIL stall_count: tokens=%0d ctrl=%0d expected 6/3", tok, ctrl_hs);
    end
  endtask

  task automatic test_reset_mid();
    cv_b = 1;
    tick();
    cv_b = 0;
    tick();
    checks++;
    if (ov_b !== 1'b1 || o_b !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_beat2: valid=%b outs=%h expected 1/ff", ov_b, o_b);
    end
    rst = 1;
    cv_b = 1;
    tick();
    checks++;
    if (ov_b !== 1'b0 || o_b !== 8'hFE || cr_b !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset: valid=%b outs=%h ready=%b expected 0/fe/0", ov_b, o_b, cr_b);
    end
    tick();
    checks++;
    if (ov_b !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_accept: valid=%b expected 0", ov_b);
    end
    rst = 0;
    tick();
    cv_b = 0;
    checks++;
    if (ov_b !== 1'b1 || o_b !== 8'hFE) begin
      errors++;
      $display("FAIL rmid_restart: valid=%b outs=%h expected 1/fe", ov_b, o_b);
    end
    tick();
    checks++;
    if (o_b !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_next: outs=%h expected ff", o_b);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_ramp_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/handshake_constant_burst.md
HANDSHAKE_CONSTANT_BURST -- requirements
Module: handshake_constant_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: output data width in bits (>=1).
REQ-002 SHALL have parameter VALUE, default 0: constant/start value, truncated to DATA_WIDTH LSBs.
REQ-003 SHALL have parameter REPEAT, default 1: output tokens emitted per accepted ctrl token (>=1).
REQ-004 SHALL have parameter MODE, default 0: 0 = constant; 1 = ramp.
REQ-005 SHALL have parameter STEP, default 1: ramp increment per emitted token, truncated to DATA_WIDTH; ignored when MODE=0.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port ctrl_valid, input, 1: control token offered.
REQ-009 SHALL have port ctrl_ready, output, 1: control token accepted when high with ctrl_valid.
REQ-010 SHALL have port outs, output, DATA_WIDTH: emitted value.
REQ-011 SHALL have port outs_valid, output, 1: outs holds a valid token.
REQ-012 SHALL have port outs_ready, input, 1: downstream accepts token.

Function
REQ-013 SHALL implement FSM states IDLE and EMIT; outs_valid = (state==EMIT), driven from a register.
REQ-014 SHALL compute ctrl_ready = (state==IDLE) OR (state==EMIT AND remaining==1 AND outs_ready); no other combinational path.
REQ-015 SHALL, on ctrl handshake in IDLE, enter EMIT next cycle with remaining=REPEAT and outs=VALUE (latency: ctrl handshake cycle t -> outs_valid at t+1).
REQ-016 SHALL, on outs handshake in EMIT with remaining>1, decrement remaining; outs += STEP mod 2^DATA_WIDTH if MODE=1, else hold VALUE.
REQ-017 SHALL, on outs handshake with remaining==1 and no simultaneous ctrl handshake, return to IDLE; outs reloads VALUE.
REQ-018 SHALL, on outs handshake with remaining==1 and simultaneous ctrl handshake, stay in EMIT, reload remaining=REPEAT and outs=VALUE (back-to-back bursts, no bubble).
REQ-019 SHALL hold outs, outs_valid, and remaining stable while outs_valid=1 and outs_ready=0.
REQ-020 SHALL never drop or duplicate tokens: exactly REPEAT outs handshakes per ctrl handshake.
REQ-021 SHALL wrap ramp arithmetic modulo 2^DATA_WIDTH with no saturation or flag.
REQ-022 SHALL, with MODE=0, drive outs == VALUE[DATA_WIDTH-1:0] at all times after reset.
REQ-023 SHALL size the remaining counter as clog2(REPEAT+1) bits; REPEAT=1 is legal (one token per ctrl, 1-cycle registered latency).
REQ-024 SHALL ignore ctrl_valid while in EMIT except at the last-beat condition of REQ-014.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set state=IDLE, outs_valid=0, remaining=0, outs=VALUE[DATA_WIDTH-1:0].
REQ-026 SHALL drive ctrl_ready=0 while rst=1 and accept no token in that cycle.
REQ-027 SHALL abort an in-progress burst on rst mid-EMIT with no further outs tokens; the next ctrl token starts a fresh burst.

Verification
REQ-028 SHALL cover: DATA_WIDTH=12, VALUE=0xE8C, REPEAT=1, MODE=0, outs_ready=1, one ctrl token -> outs_valid one cycle later, outs=0xE8C, exactly one handshake, return to IDLE.
REQ-029 SHALL cover: DATA_WIDTH=8, VALUE=0xFE, STEP=1, MODE=1, REPEAT=4 -> outs sequence 0xFE,0xFF,0x00,0x01, then IDLE.
REQ-030 SHALL cover: REPEAT=3, ctrl_valid held high, outs_ready=1 -> continuous outs_valid, ctrl_ready pulses on every third beat, 6 outs per 2 ctrl tokens, no bubble.
REQ-031 SHALL cover: REPEAT=2, outs_ready random 50% -> outs stable during stall, token count = 2 x ctrl count, ramp order preserved.
REQ-032 SHALL cover: rst asserted after second beat of a REPEAT=4 burst -> next cycle outs_valid=0, ctrl_ready=0 during reset, new ctrl token restarts at VALUE.
